display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: digit select, coherent digit snapshot, field blink.
// Optional LEAD_ZERO_BLANK_EN blanks a zero hours-tens digit.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] min_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] hour_units,
    input  logic [3:0] hour_tens,
    input  logic       adjust_mode,
    input  logic       adjust_field,
    input  logic       display_on,
    output logic [3:0] numbers,
    output logic [1:0] sw,
    output logic       enable
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0]     refresh_cnt;
    logic [BW-1:0]     blink_cnt;
    logic              blink_phase;
    logic              adjust_q;
    logic              shadow_valid;
    logic [3:0][3:0]   shadow;

    logic              scan_tick_c;
    logic              blink_wrap_c;
    logic              adjust_rise_c;
    logic              phase_nxt_c;
    logic [1:0]        sw_nxt_c;
    logic              load_c;
    logic [3:0][3:0]   shadow_nxt_c;
    logic              in_field_c;
    logic              blink_blank_c;
    logic              lead_blank_c;
    logic              enable_nxt_c;

    // Next-slot digit, enable and blink phase, all resolved for the value sw is about to take.
    always_comb begin
        scan_tick_c   = (refresh_cnt == REFRESH_LAST);
        blink_wrap_c  = (blink_cnt == BLINK_LAST);
        adjust_rise_c = adjust_mode & ~adjust_q;
        phase_nxt_c   = blink_phase;
        if (adjust_rise_c) begin
            phase_nxt_c = 1'b1;
        end else if (blink_wrap_c) begin
            phase_nxt_c = ~blink_phase;
        end
        sw_nxt_c      = sw + 2'd1;
        load_c        = scan_tick_c & ((sw == 2'b11) | ~shadow_valid);
        shadow_nxt_c  = shadow;
        if (load_c) begin
            shadow_nxt_c = {hour_tens, hour_units, min_tens, min_units};
        end
        in_field_c    = adjust_field ? sw_nxt_c[1] : ~sw_nxt_c[1];
        blink_blank_c = adjust_mode & ~phase_nxt_c & in_field_c;
`ifdef LEAD_ZERO_BLANK_EN
        lead_blank_c  = (sw_nxt_c == 2'b11) && (shadow_nxt_c[3] == 4'd0);
`else
        lead_blank_c  = 1'b0;
`endif
        enable_nxt_c  = display_on & ~blink_blank_c & ~lead_blank_c;
    end

    // Refresh divider sets the digit slot length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (scan_tick_c) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Free-running blink divider, restarted visible on entry to adjust mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            adjust_q    <= 1'b0;
        end else begin
            adjust_q    <= adjust_mode;
            blink_phase <= phase_nxt_c;
            if (adjust_rise_c || blink_wrap_c) begin
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Shadow digits reload only at frame start (and on the very first slot after reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow       <= '0;
            shadow_valid <= 1'b0;
        end else if (load_c) begin
            shadow       <= shadow_nxt_c;
            shadow_valid <= 1'b1;
        end
    end

    // Outputs advance together once per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw      <= 2'b00;
            numbers <= 4'd0;
            enable  <= 1'b0;
        end else if (scan_tick_c) begin
            sw      <= sw_nxt_c;
            numbers <= shadow_nxt_c[sw_nxt_c];
            enable  <= enable_nxt_c;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed, table-driven bench for display_scan_ctrl (fast scan instance and fast blink instance).
module tb_display_scan_ctrl;

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] mu;
        logic [3:0] mt;
        logic [3:0] hu;
        logic [3:0] ht;
        logic       disp;
        logic       am;
        logic       af;
        logic [1:0] sw;
        logic [3:0] num;
        logic       en;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] min_units, min_tens, hour_units, hour_tens;
    logic       adjust_mode, adjust_field, display_on;
    logic [3:0] s_numbers, b_numbers;
    logic [1:0] s_sw, b_sw;
    logic       s_enable, b_enable;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t scan_vec[27];
    vec_t blink_vec[26];

    display_scan_ctrl #(.REFRESH_DIV(4), .BLINK_DIV(1000)) u_scan (
        .clk(clk), .rst_n(rst_n),
        .min_units(min_units), .min_tens(min_tens),
        .hour_units(hour_units), .hour_tens(hour_tens),
        .adjust_mode(adjust_mode), .adjust_field(adjust_field), .display_on(display_on),
        .numbers(s_numbers), .sw(s_sw), .enable(s_enable)
    );

    display_scan_ctrl #(.REFRESH_DIV(2), .BLINK_DIV(8)) u_blink (
        .clk(clk), .rst_n(rst_n),
        .min_units(min_units), .min_tens(min_tens),
        .hour_units(hour_units), .hour_tens(hour_tens),
        .adjust_mode(adjust_mode), .adjust_field(adjust_field), .display_on(display_on),
        .numbers(b_numbers), .sw(b_sw), .enable(b_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] mu, input logic [3:0] mt,
                                input logic [3:0] hu, input logic [3:0] ht,
                                input logic disp, input logic am, input logic af,
                                input logic [1:0] sw, input logic [3:0] num, input logic en);
        vec_t v;
        v.mu = mu; v.mt = mt; v.hu = hu; v.ht = ht;
        v.disp = disp; v.am = am; v.af = af;
        v.sw = sw; v.num = num; v.en = en;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        min_units = v.mu; min_tens = v.mt; hour_units = v.hu; hour_tens = v.ht;
        display_on = v.disp; adjust_mode = v.am; adjust_field = v.af;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_row(input string tag, input int idx, input vec_t v,
                           input bit use_blink, input int clks);
        drive(v);
        wait_clks(clks);
        if (use_blink) begin
            check($sformatf("%s[%0d].sw", tag, idx), {2'b00, b_sw}, {2'b00, v.sw});
            check($sformatf("%s[%0d].numbers", tag, idx), b_numbers, v.num);
            check($sformatf("%s[%0d].enable", tag, idx), {3'b000, b_enable}, {3'b000, v.en});
        end else begin
            check($sformatf("%s[%0d].sw", tag, idx), {2'b00, s_sw}, {2'b00, v.sw});
            check($sformatf("%s[%0d].numbers", tag, idx), s_numbers, v.num);
            check($sformatf("%s[%0d].enable", tag, idx), {3'b000, s_enable}, {3'b000, v.en});
        end
    endtask

    initial begin
        // Scan instance: inputs {mu,mt,hu,ht,disp,am,af} -> {sw,numbers,enable} after each slot.
        scan_vec[0]  = mk(4, 3, 2, 1, 1, 0, 0, 2'd1, 4'd3, 1);
        scan_vec[1]  = mk(4, 3, 2, 1, 1, 0, 0, 2'd2, 4'd2, 1);
        scan_vec[2]  = mk(4, 3, 2, 1, 1, 0, 0, 2'd3, 4'd1, 1);
        scan_vec[3]  = mk(4, 3, 2, 1, 1, 0, 0, 2'd0, 4'd4, 1);
        scan_vec[4]  = mk(4, 3, 2, 1, 1, 0, 0, 2'd1, 4'd3, 1);
        scan_vec[5]  = mk(4, 3, 2, 1, 1, 0, 0, 2'd2, 4'd2, 1);
        scan_vec[6]  = mk(5, 3, 2, 1, 1, 0, 0, 2'd3, 4'd1, 1);
        scan_vec[7]  = mk(5, 3, 2, 1, 1, 0, 0, 2'd0, 4'd5, 1);
        scan_vec[8]  = mk(5, 9, 2, 1, 1, 0, 0, 2'd1, 4'd3, 1);
        scan_vec[9]  = mk(5, 9, 2, 1, 1, 0, 0, 2'd2, 4'd2, 1);
        scan_vec[10] = mk(5, 9, 2, 1, 1, 0, 0, 2'd3, 4'd1, 1);
        scan_vec[11] = mk(5, 9, 2, 1, 1, 0, 0, 2'd0, 4'd5, 1);
        scan_vec[12] = mk(5, 9, 2, 1, 1, 0, 0, 2'd1, 4'd9, 1);
        scan_vec[13] = mk(5, 9, 2, 1, 0, 0, 0, 2'd2, 4'd2, 0);
        scan_vec[14] = mk(5, 9, 2, 1, 0, 0, 0, 2'd3, 4'd1, 0);
        scan_vec[15] = mk(5, 9, 2, 1, 0, 0, 0, 2'd0, 4'd5, 0);
        scan_vec[16] = mk(5, 9, 2, 1, 0, 0, 0, 2'd1, 4'd9, 0);
        scan_vec[17] = mk(5, 9, 2, 4'hC, 1, 0, 0, 2'd2, 4'd2, 1);
        scan_vec[18] = mk(5, 9, 2, 4'hC, 1, 0, 0, 2'd3, 4'd1, 1);
        scan_vec[19] = mk(5, 9, 2, 4'hC, 1, 0, 0, 2'd0, 4'd5, 1);
        scan_vec[20] = mk(5, 9, 2, 4'hC, 1, 0, 0, 2'd1, 4'd9, 1);
        scan_vec[21] = mk(5, 9, 2, 4'hC, 1, 0, 0, 2'd2, 4'd2, 1);
        scan_vec[22] = mk(5, 9, 2, 4'hC, 1, 0, 0, 2'd3, 4'hC, 1);
        scan_vec[23] = mk(5, 9, 7, 0, 1, 0, 0, 2'd0, 4'd5, 1);
        scan_vec[24] = mk(5, 9, 7, 0, 1, 0, 0, 2'd1, 4'd9, 1);
        scan_vec[25] = mk(5, 9, 7, 0, 1, 0, 0, 2'd2, 4'd7, 1);
        scan_vec[26] = mk(5, 9, 7, 0, 1, 0, 0, 2'd3, 4'd0, !LZ);

        // Blink instance: adjust entry seen at clk 3, phase 0 during clks 11-18, 27-34, 43-50.
        blink_vec[0]  = mk(4, 3, 2, 1, 1, 0, 1, 2'd1, 4'd3, 1);
        for (int i = 1; i <= 12; i++)
            blink_vec[i] = mk(4, 3, 2, 1, 1, 1, 1, 2'((i + 1) % 4), 4'd0, 1);
        for (int i = 13; i <= 23; i++)
            blink_vec[i] = mk(4, 3, 2, 1, 1, 1, 0, 2'((i + 1) % 4), 4'd0, 1);
        for (int i = 24; i <= 25; i++)
            blink_vec[i] = mk(4, 3, 2, 1, 1, 0, 0, 2'((i + 1) % 4), 4'd0, 1);
        for (int i = 0; i <= 25; i++) begin
            case (blink_vec[i].sw)
                2'd0: blink_vec[i].num = 4'd4;
                2'd1: blink_vec[i].num = 4'd3;
                2'd2: blink_vec[i].num = 4'd2;
                default: blink_vec[i].num = 4'd1;
            endcase
        end
        blink_vec[5].en  = 1'b0;
        blink_vec[6].en  = 1'b0;
        blink_vec[15].en = 1'b0;
        blink_vec[16].en = 1'b0;
        blink_vec[23].en = 1'b0;

        // Reset state and first slot.
        rst_n = 1'b0;
        drive(scan_vec[0]);
        #12;
        check("reset.sw", {2'b00, s_sw}, 4'd0);
        check("reset.numbers", s_numbers, 4'd0);
        check("reset.enable", {3'b000, s_enable}, 4'd0);
        do_reset();
        wait_clks(3);
        check("pre_tick.sw", {2'b00, s_sw}, 4'd0);
        check("pre_tick.enable", {3'b000, s_enable}, 4'd0);
        check("pre_tick.numbers", s_numbers, 4'd0);

        for (int i = 0; i < 27; i++)
            run_row("scan", i, scan_vec[i], 1'b0, (i == 0) ? 1 : 4);

        // Asynchronous reset mid-scan, then restart from sw=00.
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset.sw", {2'b00, s_sw}, 4'd0);
        check("mid_reset.numbers", s_numbers, 4'd0);
        check("mid_reset.enable", {3'b000, s_enable}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(3);
        check("restart.pre_tick.enable", {3'b000, s_enable}, 4'd0);
        wait_clks(1);
        check("restart.sw", {2'b00, s_sw}, 4'd1);
        check("restart.numbers", s_numbers, 4'd9);
        check("restart.enable", {3'b000, s_enable}, 4'd1);

        // Blink field selection and adjust entry.
        drive(blink_vec[0]);
        do_reset();
        for (int i = 0; i < 26; i++)
            run_row("blink", i, blink_vec[i], 1'b1, 2);

        // Blink toggle coincident with scan tick: enable follows the post-toggle phase.
        drive(mk(4, 3, 2, 1, 1, 0, 0, 2'd0, 4'd0, 0));
        do_reset();
        wait_clks(1);
        adjust_mode = 1'b1;
        wait_clks(7);
        check("coincide.pre.sw", {2'b00, b_sw}, 4'd0);
        check("coincide.pre.enable", {3'b000, b_enable}, 4'd1);
        wait_clks(2);
        check("coincide.to0.sw", {2'b00, b_sw}, 4'd1);
        check("coincide.to0.enable", {3'b000, b_enable}, 4'd0);
        wait_clks(6);
        check("coincide.mid.sw", {2'b00, b_sw}, 4'd0);
        check("coincide.mid.enable", {3'b000, b_enable}, 4'd0);
        wait_clks(2);
        check("coincide.to1.sw", {2'b00, b_sw}, 4'd1);
        check("coincide.to1.enable", {3'b000, b_enable}, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
